// File: rtl/sdr_read_data_path.sv
// SDRAM read-side data path: tracks READ commands through the CAS latency, counts bursts
// and registers DQ read data for the host. Optional sticky RD_TRUNC output under SDR_RD_TRUNC_FLAG_EN.
module sdr_read_data_path #(
    parameter int DSIZE       = 32,
    parameter int CAS_LATENCY = 3
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             RD_CMD,
    input  logic [1:0]       BL_SEL,
    input  logic [DSIZE-1:0] DQIN,
    output logic [DSIZE-1:0] DATAOUT,
    output logic             DATAOUT_VALID,
    output logic             RD_LAST,
    output logic             RD_BUSY
`ifdef SDR_RD_TRUNC_FLAG_EN
    ,
    output logic             RD_TRUNC
`endif
);

    typedef struct packed {
        logic       valid;
        logic [1:0] bl;
    } token_t;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    token_t     pipe_q [CAS_LATENCY];
    token_t     head;
    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] cur_cnt;
    logic       cap_en;
    logic       cap_last;
    logic       trunc;
    logic       pipe_busy;

    // The pipeline shifts every cycle, so a new READ and an arriving head token never collide.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int i = 0; i < CAS_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= {RD_CMD, BL_SEL};
            for (int i = 1; i < CAS_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign head = pipe_q[CAS_LATENCY-1];

    // A head token starts its burst in this cycle, pre-empting any burst still running.
    // NOTE: every output of this block is given a default first, so no latch can be inferred.
    always_comb begin
        state_d  = IDLE;
        cnt_d    = '0;
        cur_cnt  = cnt_q;
        cap_en   = 1'b0;
        cap_last = 1'b0;
        trunc    = 1'b0;
        if (head.valid) begin
            cur_cnt = 3'((4'd1 << head.bl) - 4'd1);
            cap_en  = 1'b1;
            trunc   = (state_q == BURST);
        end else if (state_q == BURST) begin
            cap_en  = 1'b1;
        end
        if (cap_en) begin
            cap_last = (cur_cnt == 3'd0);
            if (cur_cnt != 3'd0) begin
                state_d = BURST;
                cnt_d   = cur_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            DATAOUT       <= '0;
            DATAOUT_VALID <= 1'b0;
            RD_LAST       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            DATAOUT_VALID <= cap_en;
            RD_LAST       <= cap_last;
            if (cap_en) DATAOUT <= DQIN;
        end
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < CAS_LATENCY; i++) pipe_busy = pipe_busy | pipe_q[i].valid;
    end

    assign RD_BUSY = pipe_busy || (state_q == BURST);

`ifdef SDR_RD_TRUNC_FLAG_EN
    always_ff @(posedge CLK) begin
        if (!RESET_N)  RD_TRUNC <= 1'b0;
        else if (trunc) RD_TRUNC <= 1'b1;
    end
`else
    logic unused_trunc;
    assign unused_trunc = trunc;
`endif

endmodule

// File: tb/tb_sdr_read_data_path.sv
// Scoreboard bench for sdr_read_data_path: two instances (CAS latency 3 and 2) share stimulus
// and are checked against a per-edge schedule of expected read words.
module tb_sdr_read_data_path;

    localparam int DSIZE = 32;
    localparam int MAXC  = 4096;

    typedef struct {
        logic [DSIZE-1:0] data;
        logic             last;
    } word_t;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic             RD_CMD = 1'b0;
    logic [1:0]       BL_SEL = 2'b00;
    logic [DSIZE-1:0] DQIN = '0;

    logic [DSIZE-1:0] dout3, dout2;
    logic             vld3, vld2, last3, last2, busy3, busy2;
    logic             tr3, tr2;

    always #5 CLK = ~CLK;

    sdr_read_data_path #(.DSIZE(DSIZE), .CAS_LATENCY(3)) u_cl3 (
        .CLK(CLK), .RESET_N(RESET_N), .RD_CMD(RD_CMD), .BL_SEL(BL_SEL), .DQIN(DQIN),
        .DATAOUT(dout3), .DATAOUT_VALID(vld3), .RD_LAST(last3), .RD_BUSY(busy3)
`ifdef SDR_RD_TRUNC_FLAG_EN
        , .RD_TRUNC(tr3)
`endif
    );

    sdr_read_data_path #(.DSIZE(DSIZE), .CAS_LATENCY(2)) u_cl2 (
        .CLK(CLK), .RESET_N(RESET_N), .RD_CMD(RD_CMD), .BL_SEL(BL_SEL), .DQIN(DQIN),
        .DATAOUT(dout2), .DATAOUT_VALID(vld2), .RD_LAST(last2), .RD_BUSY(busy2)
`ifdef SDR_RD_TRUNC_FLAG_EN
        , .RD_TRUNC(tr2)
`endif
    );

`ifndef SDR_RD_TRUNC_FLAG_EN
    assign tr3 = 1'b0;
    assign tr2 = 1'b0;
`endif

    // Reference model: for each edge number, whether a word is expected there and whether it ends its burst.
    bit               sv [2][MAXC];
    bit               sl [2][MAXC];
    bit               st [2][MAXC];
    logic             exp_v    [2];
    logic             exp_l    [2];
    logic             exp_b    [2];
    logic             exp_tr   [2];
    logic [DSIZE-1:0] exp_dout [2];
    word_t            q0[$];
    word_t            q1[$];
    int               cyc = 0;
    bit               mon_en = 0;
    int               n_checks = 0;
    int               n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input logic rst_n, input logic rd, input logic [1:0] bl,
                        input logic [DSIZE-1:0] dq);
        word_t w;
        @(negedge CLK);
        RESET_N = rst_n;
        RD_CMD  = rd;
        BL_SEL  = bl;
        DQIN    = dq;
        for (int d = 0; d < 2; d++) begin
            int cl;
            cl = (d == 0) ? 3 : 2;
            if (!rst_n) begin
                for (int e = cyc; e < cyc + 20; e++) begin
                    sv[d][e] = 0; sl[d][e] = 0; st[d][e] = 0;
                end
                exp_v[d] = 0; exp_l[d] = 0; exp_b[d] = 0; exp_tr[d] = 0; exp_dout[d] = '0;
            end else begin
                if (rd) begin
                    int s, n;
                    s = cyc + cl;
                    n = 1 << bl;
                    st[d][s] = sv[d][s];
                    for (int e = s; e < s + 9; e++) begin
                        sv[d][e] = 0; sl[d][e] = 0;
                    end
                    for (int k = 0; k < n; k++) sv[d][s+k] = 1;
                    sl[d][s+n-1] = 1;
                end
                if (st[d][cyc]) exp_tr[d] = 1;
                exp_v[d] = sv[d][cyc];
                exp_l[d] = sv[d][cyc] && sl[d][cyc];
                if (sv[d][cyc]) begin
                    exp_dout[d] = dq;
                    w.data = dq;
                    w.last = sl[d][cyc];
                    if (d == 0) q0.push_back(w);
                    else        q1.push_back(w);
                end
                exp_b[d] = 0;
                for (int e = cyc + 1; e < cyc + 13; e++) exp_b[d] = exp_b[d] | sv[d][e];
            end
        end
        cyc++;
        mon_en = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00, $urandom);
    endtask

    task automatic mon_check(input int d, input logic v, input logic l, input logic b,
                             input logic [DSIZE-1:0] dout, input logic tr);
        word_t w;
        check($sformatf("cl%0d_valid", 3 - d), 64'(v), 64'(exp_v[d]));
        check($sformatf("cl%0d_busy", 3 - d), 64'(b), 64'(exp_b[d]));
        check($sformatf("cl%0d_dataout", 3 - d), 64'(dout), 64'(exp_dout[d]));
`ifdef SDR_RD_TRUNC_FLAG_EN
        check($sformatf("cl%0d_trunc", 3 - d), 64'(tr), 64'(exp_tr[d]));
`else
        check($sformatf("cl%0d_last_idle", 3 - d), 64'(l && !v), 64'(tr));
`endif
        if (v === 1'b1) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                check($sformatf("cl%0d_unexpected_word", 3 - d), 64'(1), 64'(0));
            end else begin
                w = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("cl%0d_sb_data", 3 - d), 64'(dout), 64'(w.data));
                check($sformatf("cl%0d_sb_last", 3 - d), 64'(l), 64'(w.last));
            end
        end else begin
            check($sformatf("cl%0d_last", 3 - d), 64'(l), 64'(0));
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (mon_en) begin
                mon_check(0, vld3, last3, busy3, dout3, tr3);
                mon_check(1, vld2, last2, busy2, dout2, tr2);
            end
        end
    end

    initial begin
        // Reset held with a READ request and all-ones data on the bus.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b11, '1);
        idle(3);

        // Single BL=4 read with known data at the CL=3 capture edges.
        step(1'b1, 1'b1, 2'b10, $urandom);
        idle(2);
        step(1'b1, 1'b0, 2'b00, 32'h11);
        step(1'b1, 1'b0, 2'b00, 32'h22);
        step(1'b1, 1'b0, 2'b00, 32'h33);
        step(1'b1, 1'b0, 2'b00, 32'h44);
        idle(4);

        // Seamless BL=2 reads.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 2'b01, $urandom);
            idle(1);
        end
        idle(6);

        // BL=8 truncated by a BL=1 read two cycles later.
        step(1'b1, 1'b1, 2'b11, $urandom);
        idle(1);
        step(1'b1, 1'b1, 2'b00, $urandom);
        idle(12);

        // Lone BL=1 read.
        step(1'b1, 1'b1, 2'b00, $urandom);
        idle(6);

        // Reset in the middle of a BL=8 burst.
        step(1'b1, 1'b1, 2'b11, $urandom);
        idle(4);
        step(1'b0, 1'b0, 2'b00, $urandom);
        idle(12);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            logic rst_n, rd;
            rst_n = ($urandom_range(0, 199) != 0);
            rd    = ($urandom_range(0, 2) == 0);
            step(rst_n, rd, 2'($urandom_range(0, 3)), $urandom);
        end
        idle(20);
        @(posedge CLK);
        #2;
        check("cl3_sb_drain", 64'(q0.size()), 64'(0));
        check("cl2_sb_drain", 64'(q1.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
